// File: rtl/mm_bram_result_collector.sv
// mm_bram_result_collector: per-column result banks, row-ordered valid/ready release, optional reject counter (MM_RESULT_ERR_CNT_EN)
module mm_bram_result_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_NUM = 32,
  parameter int COL_NUM = 32,
  localparam int ROW_ADDR_WIDTH = $clog2(ROW_NUM)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [DATA_WIDTH*COL_NUM-1:0]        dp_row_data,
  input  logic [ROW_ADDR_WIDTH*COL_NUM-1:0]    dp_row_wraddr,
  input  logic [COL_NUM-1:0]                   dp_row_wr_en,
  output logic [DATA_WIDTH*COL_NUM-1:0]        out_data,
  output logic [ROW_ADDR_WIDTH-1:0]            out_row,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_last,
  output logic                                 done,
  input  logic                                 clear,
  output logic                                 err
`ifdef MM_RESULT_ERR_CNT_EN
  , output logic [15:0]                        err_cnt
`endif
);
  typedef enum logic {COLLECT, DONE} state_t;
  state_t state;
  logic [ROW_ADDR_WIDTH-1:0] rd_ptr;
  logic [COL_NUM-1:0] mask [ROW_NUM];
  logic [DATA_WIDTH-1:0] bank [COL_NUM][ROW_NUM];
  logic [ROW_ADDR_WIDTH-1:0] wa [COL_NUM];
  logic [COL_NUM-1:0] acc, rej;
  logic fire, at_last;
  // a write to an already-written cell (including a complete row being released) is rejected
  always_comb begin
    for (int c = 0; c < COL_NUM; c++) begin
      wa[c] = dp_row_wraddr[c*ROW_ADDR_WIDTH +: ROW_ADDR_WIDTH];
      acc[c] = dp_row_wr_en[c] && state == COLLECT && 32'(wa[c]) < ROW_NUM && !mask[wa[c]][c];
      rej[c] = dp_row_wr_en[c] && !acc[c];
      out_data[c*DATA_WIDTH +: DATA_WIDTH] = bank[c][rd_ptr];
    end
  end
  assign out_valid = state == COLLECT && &mask[rd_ptr];
  assign at_last = rd_ptr == ROW_ADDR_WIDTH'(ROW_NUM - 1);
  assign out_last = out_valid && at_last;
  assign out_row = rd_ptr;
  assign done = state == DONE;
  assign fire = out_valid && out_ready;
  always_ff @(posedge clk) begin
    for (int c = 0; c < COL_NUM; c++)
      if (acc[c] && !clear) bank[c][wa[c]] <= dp_row_data[c*DATA_WIDTH +: DATA_WIDTH];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset || clear) begin
      state <= COLLECT;
      rd_ptr <= '0;
      err <= 1'b0;
      for (int r = 0; r < ROW_NUM; r++) mask[r] <= '0;
    end else begin
      if (|rej) err <= 1'b1;
      if (fire) begin
        mask[rd_ptr] <= '0;
        rd_ptr <= at_last ? '0 : rd_ptr + 1'b1;
        if (at_last) state <= DONE;
      end
      for (int c = 0; c < COL_NUM; c++)
        if (acc[c]) mask[wa[c]][c] <= 1'b1;
    end
  end
`ifdef MM_RESULT_ERR_CNT_EN
  logic [16:0] cnt_sum;
  always_comb begin
    cnt_sum = {1'b0, err_cnt};
    for (int c = 0; c < COL_NUM; c++) cnt_sum = cnt_sum + 17'(rej[c]);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset || clear) err_cnt <= '0;
    else err_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end
`endif
endmodule
